// File: rtl/otg_hpi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : otg_hpi_pkg
//  Brief    : Shared types and constants for the CY7C67200 HPI bus sequencer
//  Revision : 1.0  initial release
// ============================================================================
package otg_hpi_pkg;

  // Sequencer states; one HPI bus cycle walks SETUP -> PULSE -> HOLD -> DONE
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } hpi_state_e;

  // HPI register select values as seen on otg_addr
  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // Largest of three phase lengths; sizes the shared phase counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/otg_hpi_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : otg_hpi_bus_ctrl_if
//  Brief    : Avalon-MM slave side plus HPI pin side of the OTG bus sequencer
//  Revision : 1.0  initial release
// ============================================================================
interface otg_hpi_bus_ctrl_if;

  // Avalon-MM slave
  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_read;
  logic        avs_write;
  logic [15:0] avs_writedata;
  logic [15:0] avs_readdata;
  logic        avs_waitrequest;

  // HPI pins
  logic [1:0]  otg_addr;
  logic        otg_cs_n;
  logic        otg_rd_n;
  logic        otg_wr_n;
  logic [15:0] otg_data_out;
  logic        otg_data_oe;
  logic [15:0] otg_data_in;
  logic        otg_int;
  logic        irq;

  // Sequencer view
  modport slave (
    input  avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest,
    output otg_addr, otg_cs_n, otg_rd_n, otg_wr_n, otg_data_out, otg_data_oe,
    input  otg_data_in, otg_int,
    output irq
  );

  // Fabric / pin-model view
  modport master (
    output avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest,
    input  otg_addr, otg_cs_n, otg_rd_n, otg_wr_n, otg_data_out, otg_data_oe,
    output otg_data_in, otg_int,
    input  irq
  );

endinterface
`default_nettype wire

// File: rtl/otg_hpi_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : otg_hpi_sync2
//  Brief    : Two-flop synchroniser for the asynchronous OTG interrupt line
//  Revision : 1.0  initial release
// ============================================================================
module otg_hpi_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; the first may go metastable, the second settles it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/otg_hpi_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : otg_hpi_bus_ctrl
//  Brief    : Turns single Avalon-MM accesses into timed CY7C67200 HPI bus
//             cycles (setup / strobe / hold) and synchronises the OTG irq
//  Revision : 1.0  initial release
// ============================================================================
module otg_hpi_bus_ctrl
  import otg_hpi_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  otg_hpi_bus_ctrl_if.slave bus
);

  // Phase lengths below one would let a strobe move together with cs_n
  if (SETUP_CYC < 1) begin : g_chk_setup
    $fatal(1, "otg_hpi_bus_ctrl: SETUP_CYC must be >= 1");
  end
  if (PULSE_CYC < 1) begin : g_chk_pulse
    $fatal(1, "otg_hpi_bus_ctrl: PULSE_CYC must be >= 1");
  end
  if (HOLD_CYC < 1) begin : g_chk_hold
    $fatal(1, "otg_hpi_bus_ctrl: HOLD_CYC must be >= 1");
  end

  localparam int C_MAX_CYC = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam int C_CNT_W   = $clog2(C_MAX_CYC + 1);

  // Counter reload values: phase ends when the counter reaches zero
  localparam logic [C_CNT_W-1:0] C_SETUP_LD = C_CNT_W'(SETUP_CYC - 1);
  localparam logic [C_CNT_W-1:0] C_PULSE_LD = C_CNT_W'(PULSE_CYC - 1);
  localparam logic [C_CNT_W-1:0] C_HOLD_LD  = C_CNT_W'(HOLD_CYC - 1);

  hpi_state_e         r_state;
  hpi_state_e         w_state_next;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] w_cnt_next;
  logic               r_dir_wr;
  logic               w_dir_wr_next;
  logic               w_req;
  logic               w_accept;
  logic               w_capture;
  logic               w_busy_next;

  logic [1:0]         r_addr;
  logic [15:0]        r_wdata;
  logic [15:0]        r_rdata;
  logic               r_cs_n;
  logic               r_rd_n;
  logic               r_wr_n;
  logic               r_oe;

  assign w_req = bus.avs_chipselect & (bus.avs_read | bus.avs_write);

  // Next-state, phase counter reload and read-capture strobe
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_accept     = 1'b1;
          w_state_next = ST_SETUP;
          w_cnt_next   = C_SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_next = ST_PULSE;
          w_cnt_next   = C_PULSE_LD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_state_next = ST_HOLD;
          w_cnt_next   = C_HOLD_LD;
          w_capture    = ~r_dir_wr;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_next = ST_DONE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Write wins when read and write arrive together
  assign w_dir_wr_next = w_accept ? bus.avs_write : r_dir_wr;
  assign w_busy_next   = (w_state_next == ST_SETUP) ||
                         (w_state_next == ST_PULSE) ||
                         (w_state_next == ST_HOLD);

  // FSM state, phase counter and latched direction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_dir_wr <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_dir_wr <= w_dir_wr_next;
    end
  end

  // Pin strobes registered from the next state so they are glitch-free
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_n <= 1'b1;
      r_rd_n <= 1'b1;
      r_wr_n <= 1'b1;
      r_oe   <= 1'b0;
    end else begin
      r_cs_n <= ~w_busy_next;
      r_rd_n <= ~((w_state_next == ST_PULSE) & ~w_dir_wr_next);
      r_wr_n <= ~((w_state_next == ST_PULSE) &  w_dir_wr_next);
      r_oe   <= w_busy_next & w_dir_wr_next;
    end
  end

  // Address and write data latched on accept and held until the next one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= 2'd0;
      r_wdata <= 16'h0000;
    end else if (w_accept) begin
      r_addr  <= bus.avs_address;
      r_wdata <= bus.avs_writedata;
    end
  end

  // Read data sampled on the edge that ends the strobe, held until next read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= 16'h0000;
    end else if (w_capture) begin
      r_rdata <= bus.otg_data_in;
    end
  end

  otg_hpi_sync2 u_irq_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (bus.otg_int),
    .o_sync  (bus.irq)
  );

  // Stall only a selected request; DONE is the single acknowledge cycle
  assign bus.avs_waitrequest = w_req & (r_state != ST_DONE);
  assign bus.avs_readdata    = r_rdata;
  assign bus.otg_addr        = r_addr;
  assign bus.otg_data_out    = r_wdata;
  assign bus.otg_cs_n        = r_cs_n;
  assign bus.otg_rd_n        = r_rd_n;
  assign bus.otg_wr_n        = r_wr_n;
  assign bus.otg_data_oe     = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_otg_hpi_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_otg_hpi_bus_ctrl
//  Brief    : Self-checking bench for otg_hpi_bus_ctrl (default and minimum
//             timing instances)
//  Revision : 1.0  initial release
// ============================================================================
module tb_otg_hpi_bus_ctrl;
  import otg_hpi_pkg::*;

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] data;
    bit          is_wr;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;
  int   nest_err_a;
  int   nest_err_b;
  logic [15:0] rsp_a;
  logic [15:0] rsp_b;
  exp_t sb_q[$];

  otg_hpi_bus_ctrl_if bus_a ();
  otg_hpi_bus_ctrl_if bus_b ();

  otg_hpi_bus_ctrl #(.SETUP_CYC(2), .PULSE_CYC(4), .HOLD_CYC(2)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a.slave)
  );

  otg_hpi_bus_ctrl #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b.slave)
  );

  // HPI chip models: drive the response only while the read strobe is low
  assign bus_a.otg_data_in = (bus_a.otg_rd_n == 1'b0) ? rsp_a : 16'h0000;
  assign bus_b.otg_data_in = (bus_b.otg_rd_n == 1'b0) ? rsp_b : 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe-without-select watchdog on both instances
  always @(negedge clk) begin
    if (reset_n && (!bus_a.otg_rd_n || !bus_a.otg_wr_n) && bus_a.otg_cs_n) nest_err_a++;
    if (reset_n && (!bus_b.otg_rd_n || !bus_b.otg_wr_n) && bus_b.otg_cs_n) nest_err_b++;
  end

  task automatic test_reset();
    logic [4:0] obs;
    reset_n = 1'b0;
    #12;
    obs = {bus_a.otg_cs_n, bus_a.otg_rd_n, bus_a.otg_wr_n, bus_a.otg_data_oe, bus_a.avs_waitrequest};
    n_vec++;
    if (obs !== 5'b11100) begin
      n_err++; $display("FAIL reset_pins: got %b want %b", obs, 5'b11100);
    end
    n_vec++;
    if (bus_a.otg_addr !== 2'd0 || bus_a.otg_data_out !== 16'h0 || bus_a.avs_readdata !== 16'h0 || bus_a.irq !== 1'b0) begin
      n_err++; $display("FAIL reset_regs: addr=%h dout=%h rdata=%h irq=%b want all 0",
                        bus_a.otg_addr, bus_a.otg_data_out, bus_a.avs_readdata, bus_a.irq);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (dut_a.r_state !== ST_IDLE || bus_a.otg_cs_n !== 1'b1) begin
      n_err++; $display("FAIL reset_idle: state=%0d cs_n=%b want IDLE/1", dut_a.r_state, bus_a.otg_cs_n);
    end
  endtask

  // One complete access on the default-timing instance; caller is #1 after an edge
  task automatic xfer_a(input logic [1:0] a, input logic [15:0] d, input bit rd,
                        input bit wr, input logic [15:0] rsp, input string name);
    exp_t e;
    logic [4:0] exp_pins;
    logic [4:0] obs;
    bit in_cs, in_strb;
    e.addr  = a;
    e.is_wr = wr;
    e.data  = wr ? d : rsp;
    sb_q.push_back(e);
    rsp_a = rsp;
    bus_a.avs_address    = a;
    bus_a.avs_writedata  = d;
    bus_a.avs_read       = rd;
    bus_a.avs_write      = wr;
    bus_a.avs_chipselect = 1'b1;
    #1;
    n_vec++;
    if (bus_a.avs_waitrequest !== 1'b1) begin
      n_err++; $display("FAIL %s_wait_c0: got %b want 1", name, bus_a.avs_waitrequest);
    end
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      in_cs    = (cyc >= 1) && (cyc <= 8);
      in_strb  = (cyc >= 3) && (cyc <= 6);
      exp_pins = {!in_cs, !(in_strb && !wr), !(in_strb && wr), in_cs && wr, cyc < 9};
      obs = {bus_a.otg_cs_n, bus_a.otg_rd_n, bus_a.otg_wr_n, bus_a.otg_data_oe, bus_a.avs_waitrequest};
      n_vec++;
      if (obs !== exp_pins) begin
        n_err++; $display("FAIL %s_pins_c%0d: got %b want %b (cs_n rd_n wr_n oe wait)", name, cyc, obs, exp_pins);
      end
      if (cyc == 9) begin
        e = sb_q.pop_front();
        n_vec++;
        if (bus_a.otg_addr !== e.addr) begin
          n_err++; $display("FAIL %s_addr: got %0d want %0d", name, bus_a.otg_addr, e.addr);
        end
        n_vec++;
        if (e.is_wr && bus_a.otg_data_out !== e.data) begin
          n_err++; $display("FAIL %s_dout: got %h want %h", name, bus_a.otg_data_out, e.data);
        end else if (!e.is_wr && bus_a.avs_readdata !== e.data) begin
          n_err++; $display("FAIL %s_rdata: got %h want %h", name, bus_a.avs_readdata, e.data);
        end
        bus_a.avs_chipselect = 1'b0;
        bus_a.avs_read       = 1'b0;
        bus_a.avs_write      = 1'b0;
      end
    end
  endtask

  task automatic test_write();
    xfer_a(HPI_ADDRESS, 16'h1234, 1'b0, 1'b1, 16'h0000, "write");
  endtask

  task automatic test_read();
    xfer_a(HPI_DATA, 16'h0000, 1'b1, 1'b0, 16'hBEEF, "read");
    n_vec++;
    if (bus_a.avs_readdata !== 16'hBEEF) begin
      n_err++; $display("FAIL read_hold: got %h want BEEF", bus_a.avs_readdata);
    end
  endtask

  task automatic test_both();
    xfer_a(HPI_MAILBOX, 16'hA55A, 1'b1, 1'b1, 16'h7777, "both");
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    bus_a.avs_address    = HPI_STATUS;
    bus_a.avs_writedata  = 16'h0F0F;
    bus_a.avs_write      = 1'b1;
    bus_a.avs_chipselect = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    n_vec++;
    if (bus_a.otg_wr_n !== 1'b0) begin
      n_err++; $display("FAIL rstmid_pre: wr_n got %b want 0", bus_a.otg_wr_n);
    end
    reset_n = 1'b0;
    #1;
    obs = {bus_a.otg_cs_n, bus_a.otg_rd_n, bus_a.otg_wr_n, bus_a.otg_data_oe};
    n_vec++;
    if (obs !== 4'b1110) begin
      n_err++; $display("FAIL rstmid_pins: got %b want 1110", obs);
    end
    n_vec++;
    if (bus_a.avs_readdata !== 16'h0 || bus_a.otg_data_out !== 16'h0 || bus_a.otg_addr !== 2'd0) begin
      n_err++; $display("FAIL rstmid_regs: rdata=%h dout=%h addr=%0d want 0", bus_a.avs_readdata,
                        bus_a.otg_data_out, bus_a.otg_addr);
    end
    bus_a.avs_chipselect = 1'b0;
    bus_a.avs_write      = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); #1;
      n_vec++;
      if (dut_a.r_state !== ST_IDLE || bus_a.otg_cs_n !== 1'b1) begin
        n_err++; $display("FAIL rstmid_idle_c%0d: state=%0d cs_n=%b want IDLE/1", cyc, dut_a.r_state, bus_a.otg_cs_n);
      end
    end
    xfer_a(HPI_STATUS, 16'h0000, 1'b1, 1'b0, 16'h5A3C, "read2");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [4:0] exp_pins;
    logic [4:0] obs;
    bit cs_on;
    e.addr = HPI_ADDRESS; e.data = 16'h8001; e.is_wr = 1'b1; sb_q.push_back(e);
    e.addr = HPI_DATA;    e.data = 16'hC3A5; e.is_wr = 1'b0; sb_q.push_back(e);
    rsp_b = 16'hC3A5;
    bus_b.avs_address    = HPI_ADDRESS;
    bus_b.avs_writedata  = 16'h8001;
    bus_b.avs_write      = 1'b1;
    bus_b.avs_read       = 1'b0;
    bus_b.avs_chipselect = 1'b1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk); #1;
      cs_on    = (cyc >= 1 && cyc <= 3) || (cyc >= 6 && cyc <= 8);
      exp_pins = {!cs_on, cyc != 7, cyc != 2, cyc >= 1 && cyc <= 3, !(cyc == 4 || cyc >= 9)};
      obs = {bus_b.otg_cs_n, bus_b.otg_rd_n, bus_b.otg_wr_n, bus_b.otg_data_oe, bus_b.avs_waitrequest};
      n_vec++;
      if (obs !== exp_pins) begin
        n_err++; $display("FAIL b2b_pins_c%0d: got %b want %b (cs_n rd_n wr_n oe wait)", cyc, obs, exp_pins);
      end
      if (cyc == 4) begin
        e = sb_q.pop_front();
        n_vec++;
        if (bus_b.otg_data_out !== e.data || bus_b.otg_addr !== e.addr) begin
          n_err++; $display("FAIL b2b_write: dout=%h addr=%0d want %h/%0d", bus_b.otg_data_out, bus_b.otg_addr, e.data, e.addr);
        end
        bus_b.avs_address = HPI_DATA;
        bus_b.avs_write   = 1'b0;
        bus_b.avs_read    = 1'b1;
      end
      if (cyc == 9) begin
        e = sb_q.pop_front();
        n_vec++;
        if (bus_b.avs_readdata !== e.data || bus_b.otg_addr !== e.addr) begin
          n_err++; $display("FAIL b2b_read: rdata=%h addr=%0d want %h/%0d", bus_b.avs_readdata, bus_b.otg_addr, e.data, e.addr);
        end
        bus_b.avs_chipselect = 1'b0;
        bus_b.avs_read       = 1'b0;
      end
    end
    n_vec++;
    if (nest_err_a !== 0 || nest_err_b !== 0) begin
      n_err++; $display("FAIL strobe_nesting: got %0d/%0d want 0/0", nest_err_a, nest_err_b);
    end
    n_vec++;
    if (sb_q.size() !== 0) begin
      n_err++; $display("FAIL scoreboard_left: got %0d want 0", sb_q.size());
    end
  endtask

  task automatic test_irq();
    logic exp_seq [4];
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b1; exp_seq[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) bus_a.otg_int = 1'b1;
      if (k == 2) bus_a.otg_int = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (bus_a.irq !== exp_seq[k]) begin
        n_err++; $display("FAIL irq_step%0d: got %b want %b", k, bus_a.irq, exp_seq[k]);
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; nest_err_a = 0; nest_err_b = 0;
    rsp_a = 16'h0; rsp_b = 16'h0;
    bus_a.avs_address = 2'd0; bus_a.avs_chipselect = 1'b0; bus_a.avs_read = 1'b0;
    bus_a.avs_write = 1'b0; bus_a.avs_writedata = 16'h0; bus_a.otg_int = 1'b0;
    bus_b.avs_address = 2'd0; bus_b.avs_chipselect = 1'b0; bus_b.avs_read = 1'b0;
    bus_b.avs_write = 1'b0; bus_b.avs_writedata = 16'h0; bus_b.otg_int = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_both();
    test_reset_mid();
    test_back_to_back();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/otg_hpi_bus_ctrl.md
# otg_hpi_bus_ctrl

Hardware sequencer for the CY7C67200 (EZ-OTG) Host Port Interface. It sits between the Nios II Avalon-MM fabric and the OTG chip pins, downstream of the software-visible HPI bus. It turns single Avalon read/write requests into complete HPI bus cycles with fixed setup, strobe and hold timing, which replaces bit-banging of the cs/rd/wr/address PIOs. It also synchronises the OTG interrupt line for the Nios IRQ fabric.

## Interface
- SETUP_CYC, 2, clk cycles with cs_n low and address/data stable before the strobe (>=1)
- PULSE_CYC, 4, clk cycles rd_n/wr_n held low (>=1)
- HOLD_CYC, 2, clk cycles cs_n low and address/data held after the strobe (>=1)
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- avs_address  in  2  HPI register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
- avs_chipselect  in  1  slave select
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_writedata  in  16  write data
- avs_readdata  out  16  read data, valid in the cycle waitrequest drops on a read
- avs_waitrequest  out  1  stall; high while a selected request is incomplete
- otg_addr  out  2  HPI address pins
- otg_cs_n  out  1  HPI chip select, active-low
- otg_rd_n  out  1  HPI read strobe, active-low
- otg_wr_n  out  1  HPI write strobe, active-low
- otg_data_out  out  16  drive value for the bidirectional data bus
- otg_data_oe  out  1  tristate enable for otg_data_out (top level builds the buffer)
- otg_data_in  in  16  sampled data bus
- otg_int  in  1  asynchronous OTG interrupt
- irq  out  1  synchronised interrupt, active-high

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, DONE.
- **IDLE:** on chipselect & (read | write), latch address, writedata and direction, then go to SETUP. If read and write are both asserted, write wins.
- **SETUP:** lasts SETUP_CYC cycles, then PULSE.
- **PULSE:** lasts PULSE_CYC cycles, then HOLD. For a read, otg_data_in is registered into avs_readdata on the clock edge that ends the last PULSE cycle.
- **HOLD:** lasts HOLD_CYC cycles, then DONE.
- **DONE:** one cycle with waitrequest low, then IDLE. A new request is accepted no earlier than the cycle after DONE.
- One down-counter is reloaded on each state entry. Its width is $clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1).
- All pin outputs are registered and decoded from the next state:
  - otg_cs_n: low in SETUP, PULSE, HOLD.
  - otg_rd_n / otg_wr_n: low in PULSE only, according to direction.
  - otg_data_oe: high in SETUP, PULSE, HOLD for writes only.
  - otg_addr and otg_data_out: hold their latched values until the next accept.
- avs_waitrequest = chipselect & (read | write) & (state != DONE). It is combinational, so the slave does not stall while unselected.
- avs_readdata holds its value until the next read capture.
- irq: otg_int passed through a two-flop synchroniser. Level, no latching.

## Timing
- **Reset values:**
  - otg_cs_n, otg_rd_n, otg_wr_n = 1.
  - otg_data_oe = 0; otg_addr = 0; otg_data_out = 0.
  - avs_readdata = 0; irq = 0; FSM in IDLE.
- **Latency:** request first seen in cycle 0, waitrequest low in cycle 1+SETUP_CYC+PULSE_CYC+HOLD_CYC. With defaults that is cycle 9.
- **Reset mid-cycle:** all strobes, cs_n and oe return to inactive immediately (asynchronous). The interrupted transaction is dropped and not retried.
- **Requester rules:** the requester must hold address, data and command stable while waitrequest is high. If the request is withdrawn mid-transaction, the HPI cycle still completes and DONE passes without an acknowledge.
- **Strobe/select nesting:** wr_n/rd_n never transition in the same cycle as cs_n. This is guaranteed by SETUP_CYC and HOLD_CYC both being >=1.

## Structure
- Shared package otg_hpi_pkg holds:
  - the state enum;
  - HPI register index constants: HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDRESS=2, HPI_STATUS=3.
- Sub-module otg_hpi_sync2 provides the two-flop synchroniser for otg_int. It is reset to 0 by reset_n.
- Parameters are checked at elaboration; any value < 1 is a fatal error.

## Test plan
- **Reset:** assert reset_n low mid-PULSE -> cs_n/rd_n/wr_n = 1 and oe = 0 within the same cycle; FSM in IDLE after release.
- **Write, defaults:** address=2, data=0x1234 -> cs_n low cycles 1–8; wr_n low cycles 3–6; oe high 1–8; otg_addr=2; data_out=0x1234; waitrequest low in cycle 9 only.
- **Read:** address=0, model drives 0xBEEF during PULSE and 0x0000 elsewhere -> avs_readdata=0xBEEF in cycle 9; rd_n low cycles 3–6; oe stays 0.
- **Minimum timing:** SETUP=PULSE=HOLD=1, back-to-back write then read -> each completes in 4 cycles; a gap of at least one IDLE cycle between cs_n pulses; rd_n/wr_n never low with cs_n high.
- **Read and write both asserted:** -> write cycle executed, rd_n stays high.
- **Interrupt:** otg_int rises -> irq high exactly 2 clk edges later; falls -> irq low 2 edges later.
